// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo -- single-clock AXI4-Stream FIFO with optional
// store-and-forward packet mode.
//
// Parameters:
//   DATA_WIDTH  tdata width in bits (multiple of 8)
//   ID_WIDTH    tid width
//   DEST_WIDTH  tdest width
//   DEPTH       capacity in beats, output register included (power of 2)
//   PACKET_MODE 1 = hold packets back until their tlast beat is stored
//
// Ports:
//   s_axis_aclk / s_axis_aresetn   clock, asynchronous active-low reset
//   s_axis_t*                      slave (write) stream
//   m_axis_t*                      master (read) stream, registered outputs
//   axis_data_count, axis_wr_data_count, axis_rd_data_count
//                                  occupancy in beats
//   axis_pkt_count                 complete packets stored
//
// Macro AXIS_PACKET_FIFO_COUNTS_EN: when defined the four count outputs
// are driven (registered one cycle); otherwise they are tied to zero.
// Packet-mode gating uses internal counters in either build.

module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DEST_WIDTH  = 4,
    parameter int DEPTH       = 512,
    parameter int PACKET_MODE = 0
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_aresetn,

    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,

    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,

    output logic [31:0]             axis_data_count,
    output logic [31:0]             axis_wr_data_count,
    output logic [31:0]             axis_rd_data_count,
    output logic [31:0]             axis_pkt_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = AW + 1;
    localparam int BW         = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH;
    localparam int LAST_BIT   = ID_WIDTH + DEST_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        LAST
    } rd_state_t;

    logic [BW-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] wr_ptr_q;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_next;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] pkt_next;

    // Free-running tlast counters: written (delayed to match wr_ptr_q) and
    // loaded into the output register. Their difference is the number of
    // complete packets sitting in memory, visible to the read side.
    logic [CW-1:0] last_wr;
    logic [CW-1:0] last_wr_q;
    logic [CW-1:0] last_rd;

    rd_state_t     state;

    logic          accept;
    logic          transfer;
    logic          avail;
    logic          pkt_ready;
    logic          release_part;
    logic          eligible;
    logic          load;
    logic [BW-1:0] rd_word;
    logic          rd_last;

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign transfer = m_axis_tvalid && m_axis_tready;

    // The read side looks at the write pointer one cycle late, which gives
    // the two-edge latency from accept to m_axis_tvalid.
    assign avail        = (wr_ptr_q != rd_ptr);
    assign pkt_ready    = (last_wr_q != last_rd);
    // Full with no complete packet: the packet can never finish, so let
    // the stored part stream out rather than deadlock.
    assign release_part = (occ == CW'(DEPTH)) && (pkt_cnt == '0);

    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_last = rd_word[LAST_BIT];

    always_comb begin
        eligible = 1'b1;
        if (PACKET_MODE != 0) begin
            eligible = (state == STREAM) || pkt_ready || release_part;
        end
    end

    assign load = avail && eligible && (!m_axis_tvalid || m_axis_tready);

    always_comb begin
        occ_next = occ;
        case ({accept, transfer})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
    end

    always_comb begin
        pkt_next = pkt_cnt;
        case ({accept && s_axis_tlast, transfer && m_axis_tlast})
            2'b10:   pkt_next = pkt_cnt + 1'b1;
            2'b01:   pkt_next = pkt_cnt - 1'b1;
            default: pkt_next = pkt_cnt;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                                    s_axis_tid, s_axis_tdest};
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            pkt_cnt       <= '0;
            last_wr       <= '0;
            last_wr_q     <= '0;
            last_rd       <= '0;
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr;
            last_wr_q <= last_wr;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (s_axis_tlast) begin
                    last_wr <= last_wr + 1'b1;
                end
            end

            occ           <= occ_next;
            pkt_cnt       <= pkt_next;
            // Registered from next occupancy: no path from m_axis_tready.
            s_axis_tready <= (occ_next < CW'(DEPTH));

            if (load) begin
                rd_ptr        <= rd_ptr + 1'b1;
                m_axis_tvalid <= 1'b1;
                {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                 m_axis_tid, m_axis_tdest} <= rd_word;
                if (rd_last) begin
                    last_rd <= last_rd + 1'b1;
                    state   <= LAST;
                end else begin
                    state   <= STREAM;
                end
            end else if (transfer) begin
                m_axis_tvalid <= 1'b0;
                if (state == LAST) begin
                    state <= IDLE;
                end
            end
        end
    end

`ifdef AXIS_PACKET_FIFO_COUNTS_EN
    logic [31:0] data_count_r;
    logic [31:0] pkt_count_r;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            data_count_r <= '0;
            pkt_count_r  <= '0;
        end else begin
            data_count_r <= 32'(occ);
            pkt_count_r  <= 32'(pkt_cnt);
        end
    end

    assign axis_data_count    = data_count_r;
    assign axis_wr_data_count = data_count_r;
    assign axis_rd_data_count = data_count_r;
    assign axis_pkt_count     = pkt_count_r;
`else
    assign axis_data_count    = '0;
    assign axis_wr_data_count = '0;
    assign axis_rd_data_count = '0;
    assign axis_pkt_count     = '0;
`endif

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Testbench for axis_packet_fifo: one instance per PACKET_MODE (0 and 1),
// both DEPTH=16. A monitor scoreboards every output beat against the
// accepted-beat queue and tracks occupancy to predict s_axis_tready.

module tb_axis_packet_fifo;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int IW    = 4;
    localparam int DSW   = 4;
    localparam int DEPTH = 16;

`ifdef AXIS_PACKET_FIFO_COUNTS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [KW-1:0]  k;
        logic           l;
        logic [IW-1:0]  id;
        logic [DSW-1:0] de;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           s_tvalid [2];
    logic           s_tready [2];
    logic           s_tlast  [2];
    logic [DW-1:0]  s_tdata  [2];
    logic [KW-1:0]  s_tkeep  [2];
    logic [IW-1:0]  s_tid    [2];
    logic [DSW-1:0] s_tdest  [2];
    logic           m_tvalid [2];
    logic           m_tready [2];
    logic           m_tlast  [2];
    logic [DW-1:0]  m_tdata  [2];
    logic [KW-1:0]  m_tkeep  [2];
    logic [IW-1:0]  m_tid    [2];
    logic [DSW-1:0] m_tdest  [2];
    logic [31:0]    data_cnt [2];
    logic [31:0]    wr_cnt   [2];
    logic [31:0]    rd_cnt   [2];
    logic [31:0]    pkt_cnt  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_packet_fifo #(
            .DATA_WIDTH (DW),
            .ID_WIDTH   (IW),
            .DEST_WIDTH (DSW),
            .DEPTH      (DEPTH),
            .PACKET_MODE(g)
        ) dut (
            .s_axis_aclk       (clk),
            .s_axis_aresetn    (rst_n),
            .s_axis_tvalid     (s_tvalid[g]),
            .s_axis_tready     (s_tready[g]),
            .s_axis_tlast      (s_tlast[g]),
            .s_axis_tdata      (s_tdata[g]),
            .s_axis_tkeep      (s_tkeep[g]),
            .s_axis_tid        (s_tid[g]),
            .s_axis_tdest      (s_tdest[g]),
            .m_axis_tvalid     (m_tvalid[g]),
            .m_axis_tready     (m_tready[g]),
            .m_axis_tlast      (m_tlast[g]),
            .m_axis_tdata      (m_tdata[g]),
            .m_axis_tkeep      (m_tkeep[g]),
            .m_axis_tid        (m_tid[g]),
            .m_axis_tdest      (m_tdest[g]),
            .axis_data_count   (data_cnt[g]),
            .axis_wr_data_count(wr_cnt[g]),
            .axis_rd_data_count(rd_cnt[g]),
            .axis_pkt_count    (pkt_cnt[g])
        );
    end

    int    vectors     = 0;
    int    miscompares = 0;

    beat_t q0 [$];
    beat_t q1 [$];
    int    occ_m      [2];
    bit    rdy_m      [2];
    bit    stall_prev [2];
    beat_t held       [2];
    bit    done       [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int i, input beat_t b);
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic pop(input int i, output beat_t b);
        if (i == 0) b = q0.pop_front();
        else        b = q1.pop_front();
    endtask

    task automatic monitor();
        beat_t out_b;
        beat_t in_b;
        beat_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                out_b = {m_tdata[i], m_tkeep[i], m_tlast[i], m_tid[i], m_tdest[i]};
                in_b  = {s_tdata[i], s_tkeep[i], s_tlast[i], s_tid[i], s_tdest[i]};
                if (!rst_n) begin
                    occ_m[i]      = 0;
                    rdy_m[i]      = 1'b0;
                    stall_prev[i] = 1'b0;
                    if (i == 0) q0.delete();
                    else        q1.delete();
                end else begin
                    check($sformatf("s_tready%0d", i), 64'(s_tready[i]), 64'(rdy_m[i]));
                    if (stall_prev[i]) begin
                        check($sformatf("hold_valid%0d", i), 64'(m_tvalid[i]), 64'd1);
                        check($sformatf("hold_payload%0d", i), 64'(out_b), 64'(held[i]));
                    end
                    if (m_tvalid[i] && m_tready[i]) begin
                        check($sformatf("beat_expected%0d", i), 64'(qsize(i) > 0), 64'd1);
                        if (qsize(i) > 0) begin
                            pop(i, e);
                            check($sformatf("out_beat%0d", i), 64'(out_b), 64'(e));
                        end
                        occ_m[i]--;
                    end
                    if (s_tvalid[i] && s_tready[i]) begin
                        push(i, in_b);
                        occ_m[i]++;
                    end
                    rdy_m[i]      = (occ_m[i] < DEPTH);
                    stall_prev[i] = m_tvalid[i] && !m_tready[i];
                    held[i]       = out_b;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted; returns at edge+1.
    task automatic send(input int i, input beat_t b);
        bit ok = 1'b0;
        int w  = 0;
        s_tdata[i]  = b.d;
        s_tkeep[i]  = b.k;
        s_tlast[i]  = b.l;
        s_tid[i]    = b.id;
        s_tdest[i]  = b.de;
        s_tvalid[i] = 1'b1;
        while (!ok && w < 200) begin
            @(negedge clk);
            ok = s_tready[i];
            @(posedge clk);
            #1;
            w++;
        end
        s_tvalid[i] = 1'b0;
        check($sformatf("send_accepted%0d", i), 64'(ok), 64'd1);
    endtask

    task automatic drain(input int i, input int bound);
        int w = 0;
        while ((qsize(i) != 0 || m_tvalid[i]) && w < bound) begin
            tick(1);
            w++;
        end
        check($sformatf("drained%0d", i), 64'(qsize(i)), 64'd0);
    endtask

    task automatic rand_stream(input int i, input int nbeats);
        int    rem = 0;
        beat_t b;
        for (int n = 0; n < nbeats; n++) begin
            if (rem == 0) rem = int'($urandom_range(1, 20));
            b.d  = $urandom;
            b.k  = 4'($urandom);
            b.id = 4'h5;
            b.de = 4'hA;
            b.l  = (rem == 1) || (n == nbeats - 1);
            rem--;
            tick(int'($urandom_range(0, 2)));
            send(i, b);
        end
    endtask

    initial begin
        beat_t b;
        int    acc;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[i] = '0;
            s_tkeep[i]  = '0;   s_tid[i]   = '0;   s_tdest[i] = '0;
            m_tready[i] = 1'b0; done[i]    = 1'b0;
        end
        fork
            monitor();
        join_none

        // Reset state
        tick(3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_tvalid%0d", i), 64'(m_tvalid[i]), 64'd0);
            check($sformatf("rst_tready%0d", i), 64'(s_tready[i]), 64'd0);
            check($sformatf("rst_tdata%0d", i), 64'(m_tdata[i]), 64'd0);
            check($sformatf("rst_count%0d", i), 64'(data_cnt[i]), 64'd0);
        end
        rst_n = 1'b1;
        check("tready_before_edge", 64'(s_tready[0]), 64'd0);
        tick(1);
        check("tready_first_edge", 64'(s_tready[0]), 64'd1);
        tick(2);

        // Latency in streaming mode: accept at N, tvalid at N+2
        m_tready[0] = 1'b1;
        b = '{d: 32'hDEADBEEF, k: 4'hF, l: 1'b1, id: 4'h5, de: 4'hA};
        send(0, b);
        check("lat_N", 64'(m_tvalid[0]), 64'd0);
        tick(1);
        check("lat_N1", 64'(m_tvalid[0]), 64'd0);
        tick(1);
        check("lat_N2_valid", 64'(m_tvalid[0]), 64'd1);
        check("lat_N2_data", 64'(m_tdata[0]), 64'hDEADBEEF);
        check("lat_N2_last", 64'(m_tlast[0]), 64'd1);
        drain(0, 20);

        // Fill to full with the read side stalled
        m_tready[0] = 1'b0;
        acc = 0;
        for (int k = 0; k < 24; k++) begin
            s_tdata[0] = 32'h100 + 32'(acc);
            s_tkeep[0] = 4'hF; s_tlast[0] = (acc == 19);
            s_tid[0] = 4'h1; s_tdest[0] = 4'h2;
            s_tvalid[0] = 1'b1;
            @(negedge clk);
            if (s_tready[0]) acc++;
            tick(1);
        end
        s_tvalid[0] = 1'b0;
        check("full_accepted", 64'(acc), 64'd16);
        check("full_tready", 64'(s_tready[0]), 64'd0);
        tick(3);
        check("full_data_count", 64'(data_cnt[0]), CNT_EN ? 64'd16 : 64'd0);
        check("full_wr_count", 64'(wr_cnt[0]), CNT_EN ? 64'd16 : 64'd0);
        check("full_rd_count", 64'(rd_cnt[0]), CNT_EN ? 64'd16 : 64'd0);
        m_tready[0] = 1'b1;
        drain(0, 100);

        // Packet mode: held back until tlast is stored
        m_tready[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b = '{d: 32'hA000 + 32'(k), k: 4'(k + 1), l: (k == 3), id: 4'h3, de: 4'h7};
            send(1, b);
            if (k < 3) begin
                tick(3);
                check($sformatf("pkt_gate_%0d", k), 64'(m_tvalid[1]), 64'd0);
            end
        end
        check("pkt_N", 64'(m_tvalid[1]), 64'd0);
        tick(1);
        check("pkt_N1", 64'(m_tvalid[1]), 64'd0);
        tick(1);
        check("pkt_N2_valid", 64'(m_tvalid[1]), 64'd1);
        check("pkt_count", 64'(pkt_cnt[1]), CNT_EN ? 64'd1 : 64'd0);
        m_tready[1] = 1'b1;
        drain(1, 50);

        // Packet mode: oversize packet released at full
        m_tready[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            b = '{d: 32'hB000 + 32'(k), k: 4'hF, l: (k == 19), id: 4'h4, de: 4'h9};
            send(1, b);
        end
        drain(1, 100);

        // Reset mid-packet
        m_tready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b = '{d: 32'hC000 + 32'(k), k: 4'hF, l: 1'b0, id: 4'h6, de: 4'h1};
            send(0, b);
        end
        tick(3);
        check("pre_rst_valid", 64'(m_tvalid[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(m_tvalid[0]), 64'd0);
        check("async_rst_tready", 64'(s_tready[0]), 64'd0);
        check("async_rst_tdata", 64'(m_tdata[0]), 64'd0);
        check("async_rst_count", 64'(data_cnt[0]), 64'd0);
        check("async_rst_pkt", 64'(pkt_cnt[0]), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_tready[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("post_rst_quiet", 64'(m_tvalid[0]), 64'd0);
        end

        // Random traffic on both instances
        fork
            begin rand_stream(0, 1000); done[0] = 1'b1; end
            begin rand_stream(1, 1000); done[1] = 1'b1; end
            begin
                while (!(done[0] && done[1])) begin
                    m_tready[0] = ($urandom_range(0, 3) != 0);
                    m_tready[1] = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        drain(0, 200);
        drain(1, 200);
        tick(3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("end_data_count%0d", i), 64'(data_cnt[i]), 64'd0);
            check($sformatf("end_pkt_count%0d", i), 64'(pkt_cnt[i]), 64'd0);
            check($sformatf("end_tready%0d", i), 64'(s_tready[i]), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, tdata width in bits (multiple of 8).
REQ-002 SHALL provide parameter ID_WIDTH, default 4, tid width.
REQ-003 SHALL provide parameter DEST_WIDTH, default 4, tdest width.
REQ-004 SHALL provide parameter DEPTH, default 512, storage in beats (power of 2, 16..4096).
REQ-005 SHALL provide parameter PACKET_MODE, default 0, 1 = store-and-forward whole packets.
REQ-006 s_axis_aclk  input  1  sole clock, all logic rising-edge.
REQ-007 s_axis_aresetn  input  1  asynchronous active-low reset.
REQ-008 s_axis_tvalid/tready/tlast  input/output/input  1 each  slave handshake and end-of-packet.
REQ-009 s_axis_tdata  input  DATA_WIDTH; s_axis_tkeep  input  DATA_WIDTH/8; s_axis_tid  input  ID_WIDTH; s_axis_tdest  input  DEST_WIDTH.
REQ-010 m_axis_tvalid/tready/tlast  output/input/output  1 each; m_axis_tdata, tkeep, tid, tdest  output  widths as slave side.
REQ-011 axis_data_count, axis_wr_data_count, axis_rd_data_count  output  32  occupancy in beats.
REQ-012 axis_pkt_count  output  32  complete packets stored.

Function
REQ-013 Beat SHALL be accepted on s_axis_tvalid && s_axis_tready; transferred out on m_axis_tvalid && m_axis_tready.
REQ-014 s_axis_tready SHALL be high iff occupancy < DEPTH; no combinational path from m_axis_tready to s_axis_tready.
REQ-015 tdata, tkeep, tlast, tid, tdest SHALL be stored per beat and emitted unchanged, in order.
REQ-016 Output SHALL be registered; with PACKET_MODE=0, a beat accepted at edge N into an empty FIFO SHALL appear on m_axis at edge N+2.
REQ-017 m_axis payload SHALL be held stable while m_axis_tvalid && !m_axis_tready.
REQ-018 Occupancy SHALL be (clog2(DEPTH)+1)-bit, incremented on accept, decremented on transfer, unchanged on simultaneous accept and transfer; zero-extended to 32 bits on the count outputs.
REQ-019 Pointers SHALL wrap modulo DEPTH without loss; full = occupancy == DEPTH, empty = occupancy == 0 (including output register).
REQ-020 With PACKET_MODE=1, m_axis_tvalid SHALL assert only when axis_pkt_count > 0 or a started packet is already in transfer.
REQ-021 axis_pkt_count SHALL increment on an accepted tlast beat, decrement on a transferred tlast beat, unchanged when both occur in one cycle.
REQ-022 With PACKET_MODE=1, if full and axis_pkt_count == 0, the stored partial packet SHALL be released (oversize cut-through) to avoid deadlock.
REQ-023 Read-side state machine SHALL have states IDLE (nothing eligible), STREAM (in packet), LAST (tlast beat presented); LAST -> IDLE/STREAM on tlast transfer, by eligibility.
REQ-024 With PACKET_MODE=0, axis_pkt_count SHALL still count but SHALL NOT gate output.

Reset
REQ-025 Assertion of s_axis_aresetn low SHALL immediately clear pointers, counts, state to IDLE, m_axis_tvalid=0, s_axis_tready=0, all count outputs 0, m_axis payload 0.
REQ-026 s_axis_tready SHALL rise on the first edge after reset deassertion.
REQ-027 Reset mid-packet SHALL discard all stored data; no partial packet SHALL emerge after reset.

Configuration
REQ-028 Macro AXIS_PACKET_FIFO_COUNTS_EN defined: axis_data_count, axis_wr_data_count, axis_rd_data_count, axis_pkt_count driven per REQ-018/021, registered one cycle.
REQ-029 Macro undefined: those four outputs SHALL be constant 0; packet-mode gating SHALL still function using internal counters.

Verification
REQ-030 PACKET_MODE=0, empty, write one beat 0xDEADBEEF tlast=1 at edge N -> m_axis_tvalid high at N+2, tdata 0xDEADBEEF, tlast 1.
REQ-031 DEPTH=16, m_axis_tready=0, write 20 beats -> 16 accepted, s_axis_tready low after 16th, axis_data_count=16; release ready -> beats 0..15 in order.
REQ-032 PACKET_MODE=1, write 3 beats of 4-beat packet -> m_axis_tvalid stays 0; 4th beat (tlast) -> tvalid after 2 edges, axis_pkt_count=1.
REQ-033 PACKET_MODE=1, DEPTH=16, 20-beat packet with m_axis_tready=1 -> release at full, all 20 beats out, no stall.
REQ-034 Continuous write and read, 1000 beats, random tvalid/tready -> sequence, tid=0x5, tdest=0xA, tkeep intact, pointers wrap, counts end 0.
REQ-035 Assert s_axis_aresetn low mid-packet (5 beats stored) -> outputs 0 immediately; after release, m_axis_tvalid stays 0 until new data.
